// File: rtl/glb_stream_capture.sv
// GLB-side sink for a ready/valid tile output stream: captures accepted words
// into a local buffer, counts them and flags completion; buffer is read back via a 1-cycle port.
module glb_stream_capture #(
   parameter int DATA_WIDTH = 17,
   parameter int DEPTH      = 2048,
   parameter int ADDR_W     = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [ADDR_W:0]       tx_size,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  valid,
   output logic                  ready,
   input  logic                  src_done,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_W:0]       count,
   output logic                  done,
   output logic                  overflow
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {IDLE, FLUSH, CAPTURE, DONE} state_t;

   state_t                state;
   logic [ADDR_W:0]       limit;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  hs;

   // flush gates ready so a word offered in the flush cycle is neither written nor seen as accepted
   assign ready = (state == CAPTURE) && !flush && (count < limit);
   assign hs    = ready && valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         limit    <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else if (flush) begin
         state    <= FLUSH;
         count    <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= IDLE;
            FLUSH: begin
               state    <= CAPTURE;
               limit    <= (tx_size > DEPTH_C) ? DEPTH_C : tx_size;
               overflow <= (tx_size > DEPTH_C);
            end
            CAPTURE: begin
               if (hs) count <= count + ONE;
               // completion looks at the registered count, so done lags the last accept by a cycle
               if (count == limit || src_done) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (hs) mem[count[ADDR_W-1:0]] <= data;
   end

   // separate read register gives read-first behaviour on same-address collisions
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_glb_stream_capture.sv
// Directed scoreboard bench for glb_stream_capture: read expectations are queued
// by stimulus and popped by a monitor when read data becomes valid.
module tb_glb_stream_capture;

   logic        clk = 1'b0;
   logic        rst, flush, valid, ready, src_done, rd_en, done, overflow;
   logic [11:0] tx_size, count;
   logic [16:0] data, rd_data;
   logic [10:0] rd_addr;

   logic [16:0] model [2048];
   logic [16:0] rdq [$];
   logic        rd_pend;
   int          n_cmp = 0;
   int          n_err = 0;

   glb_stream_capture dut (
      .clk(clk), .rst(rst), .flush(flush), .tx_size(tx_size), .data(data),
      .valid(valid), .ready(ready), .src_done(src_done), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [16:0] dv(input int t, input int i);
      logic [31:0] x;
      x = t * 32'h1000 + i;
      return {x[2], x[15:0] ^ 16'h5A5A};
   endfunction

   // monitor: read data is valid the cycle after rd_en
   always @(posedge clk or posedge rst)
      if (rst) rd_pend <= 1'b0;
      else     rd_pend <= rd_en;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
         else chk("rd_data", rd_data, rdq.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int a);
      rd_en   = 1'b1;
      rd_addr = 11'(a);
      rdq.push_back(model[a]);
      tick();
      rd_en   = 1'b0;
   endtask

   task automatic start(input int sz);
      flush = 1'b1;
      tick();
      flush   = 1'b0;
      tx_size = 12'(sz);
      tick();
   endtask

   // stream words with valid held high until ready drops or the budget runs out
   task automatic stream(input int t, input int budget, output int n);
      n = 0;
      valid = 1'b1;
      for (int g = 0; g < budget; g++) begin
         if (!ready) break;
         data = dv(t, n);
         model[n] = data;
         tick();
         n++;
      end
      valid = 1'b0;
   endtask

   initial begin
      int n;
      logic [19:0] pat;
      rst = 1'b1; flush = 1'b0; valid = 1'b0; src_done = 1'b0; rd_en = 1'b0;
      tx_size = '0; data = '0; rd_addr = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_ready", ready, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);

      // 1: 32 words back to back
      start(32);
      chk("t1_ready_first", ready, 1);
      stream(1, 40, n);
      chk("t1_handshakes", n, 32);
      chk("t1_count", count, 32);
      chk("t1_done_early", done, 0);
      tick();
      chk("t1_done", done, 1);
      chk("t1_overflow", overflow, 0);
      for (int i = 0; i < 32; i++) rd(i);

      // 2: gappy valid, extra offered words ignored
      start(8);
      pat = 20'b1011_0011_1010_1111_0110;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         valid = pat[c];
         data  = dv(2, c);
         chk("t2_ready", ready, (n < 8) ? 1 : 0);
         if (valid && ready) begin
            model[n] = data;
            n++;
         end
         tick();
      end
      valid = 1'b0;
      chk("t2_count", count, 8);
      chk("t2_done", done, 1);
      chk("t2_ready_end", ready, 0);
      for (int i = 0; i < 9; i++) rd(i);

      // 3a: src_done after 5 words, no handshake on that cycle
      start(16);
      stream(3, 5, n);
      src_done = 1'b1;
      tick();
      src_done = 1'b0;
      chk("t3a_done", done, 1);
      chk("t3a_count", count, 5);
      rd(5);
      // 3b: handshake coincides with src_done
      start(16);
      stream(4, 5, n);
      valid = 1'b1; src_done = 1'b1; data = dv(4, 5); model[5] = data;
      tick();
      valid = 1'b0; src_done = 1'b0;
      chk("t3b_done", done, 1);
      chk("t3b_count", count, 6);
      rd(5);

      // 4: oversize transfer clamps to depth
      start(3000);
      chk("t4_overflow", overflow, 1);
      stream(5, 2100, n);
      chk("t4_handshakes", n, 2048);
      chk("t4_count", count, 2048);
      tick();
      chk("t4_done", done, 1);
      rd(0); rd(2047); rd(1000);

      // 5: flush mid-capture, word offered during flush is dropped
      start(20);
      stream(6, 10, n);
      chk("t5_count_mid", count, 10);
      flush = 1'b1; valid = 1'b1; data = 17'h1FFFF;
      #1;
      chk("t5_ready_flush", ready, 0);
      tick();
      valid = 1'b0;
      chk("t5_count_clr", count, 0);
      chk("t5_done_clr", done, 0);
      chk("t5_overflow_clr", overflow, 0);
      for (int i = 0; i < 11; i++) rd(i);
      flush = 1'b0; tx_size = 12'd4;
      tick();
      // read-first: read buf[0] on the cycle it is overwritten
      rd_en = 1'b1; rd_addr = 11'd0; rdq.push_back(model[0]);
      valid = 1'b1; data = dv(7, 0); model[0] = data;
      tick();
      rd_en = 1'b0;
      for (int i = 1; i < 4; i++) begin
         data = dv(7, i); model[i] = data;
         tick();
      end
      valid = 1'b0;
      chk("t5_count_new", count, 4);
      tick();
      chk("t5_done_new", done, 1);
      for (int i = 0; i < 11; i++) rd(i);

      // 6: zero-length transfer
      start(0);
      chk("t6_ready_zero", ready, 0);
      tick();
      chk("t6_done_zero", done, 1);
      chk("t6_count_zero", count, 0);
      // async reset mid-capture
      start(16);
      stream(8, 3, n);
      rd(2);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_ready", ready, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_overflow", overflow, 0);
      chk("t6_rst_rd_data", rd_data, 0);
      tick();
      rst = 1'b0;
      tick();
      rd(0); rd(2); rd(3);
      tick(); tick();
      chk("rdq_drained", rdq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
